// File: rtl/mix_columns_engine_if.sv
// Handshake bundle for the MixColumns engine: input state channel, output state channel, busy flag.
//   in_valid/in_ready/in_state/in_inverse : producer -> engine state transfer
//   out_valid/out_ready/out_state         : engine -> consumer result transfer
//   busy                                  : engine holds a transfer (RUN or DONE)
interface mix_columns_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inverse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    // Producer/consumer side
    modport master (
        output in_valid, in_state, in_inverse, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    // Engine side
    modport slave (
        input  in_valid, in_state, in_inverse, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per RUN cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mix_columns_engine_if.slave (input/output state handshakes, busy)
// A state is accepted in IDLE, transformed in place in RUN, then held in DONE until taken.
module mix_columns_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    mix_columns_engine_if.slave bus
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned STATE_W  = 128;
    localparam logic [1:0]  COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0]  LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           col_cnt_q, col_cnt_d;
    logic [STATE_W-1:0]   work_q, work_d;
    logic [STATE_W-1:0]   out_state_q, out_state_d;
    logic                 mode_q, mode_d;
    logic                 last_q, last_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 accept_c;

    // GF(2^8) multiply by x modulo 0x11B
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by a 4-bit coefficient: XOR of xt^n(b) over the set bits of k
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] acc;
        p   = b;
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xt(p);
        end
        return acc;
    endfunction

    // One column; row 0 is the MSB byte
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a [4];
        logic [7:0] r [4];
        logic [3:0] k0, k1, k2, k3;
        k0 = inv ? 4'he : 4'h2;
        k1 = inv ? 4'hb : 4'h3;
        k2 = inv ? 4'hd : 4'h1;
        k3 = inv ? 4'h9 : 4'h1;
        a[0] = col[31:24];
        a[1] = col[23:16];
        a[2] = col[15:8];
        a[3] = col[7:0];
        for (int i = 0; i < 4; i++) begin
            r[i] = gmul(a[i], k0) ^ gmul(a[2'(i + 1)], k1)
                 ^ gmul(a[2'(i + 2)], k2) ^ gmul(a[2'(i + 3)], k3);
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    assign accept_c = bus.in_valid && in_ready_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; RUN spends one extra cycle (last_q) copying the work reg out
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept_c)      state_d = S_RUN;
            S_RUN:   if (last_q)        state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        work_d      = work_q;
        col_cnt_d   = col_cnt_q;
        mode_d      = mode_q;
        last_d      = last_q;
        out_state_d = out_state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    work_d    = bus.in_state;
                    mode_d    = bus.in_inverse;
                    col_cnt_d = 2'd0;
                    last_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (!last_q) begin
                    // Replace columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 in place
                    for (int c = 0; c < 4; c++) begin
                        if ({1'b0, 2'(2'(c) - col_cnt_q)} < 3'(COLS_PER_CYCLE)) begin
                            work_d[127 - 32*c -: 32] = mix_col(work_q[127 - 32*c -: 32], mode_q);
                        end
                    end
                    col_cnt_d = col_cnt_q + COL_STEP;
                    last_d    = (col_cnt_q == LAST_CNT);
                end else begin
                    out_state_d = work_q;
                    last_d      = 1'b0;
                end
            end
            default: ;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt_q   <= 2'd0;
            work_q      <= '0;
            mode_q      <= 1'b0;
            last_q      <= 1'b0;
            out_state_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            work_q      <= work_d;
            mode_q      <= mode_d;
            last_q      <= last_d;
            out_state_q <= out_state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (1, 2, 4 columns per cycle) share one stimulus
// stream; each has its own expected-result queue drained by a negedge monitor.
module tb_mix_columns_engine;

    localparam int NDUT = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_state;
    logic         in_inverse;
    logic         out_ready;

    logic [NDUT-1:0] in_ready_a;
    logic [NDUT-1:0] out_valid_a;
    logic [NDUT-1:0] busy_a;
    logic [127:0]    out_state_a [NDUT];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [127:0]    exp_q [NDUT][$];
    int              acc_cyc [NDUT];
    bit              pend [NDUT];
    logic [NDUT-1:0] prev_ov;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mix_columns_engine_if u_if ();
        assign u_if.in_valid   = in_valid;
        assign u_if.in_state   = in_state;
        assign u_if.in_inverse = in_inverse;
        assign u_if.out_ready  = out_ready;
        assign in_ready_a[g]   = u_if.in_ready;
        assign out_valid_a[g]  = u_if.out_valid;
        assign out_state_a[g]  = u_if.out_state;
        assign busy_a[g]       = u_if.busy;
        mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference GF(2^8) multiply (shift-and-add with reduction)
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   c [4];
        logic [7:0]   a [4];
        logic [127:0] r;
        c[0] = inv ? 8'h0e : 8'h02;
        c[1] = inv ? 8'h0b : 8'h03;
        c[2] = inv ? 8'h0d : 8'h01;
        c[3] = inv ? 8'h09 : 8'h01;
        r = '0;
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) a[row] = s[127 - 32*col - 8*row -: 8];
            for (int row = 0; row < 4; row++) begin
                logic [7:0] v;
                v = 8'h00;
                for (int k = 0; k < 4; k++) v = v ^ ref_mul(c[k], a[(row + k) % 4]);
                r[127 - 32*col - 8*row -: 8] = v;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    // Monitor: latency on out_valid rise, scoreboard compare on each output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < NDUT; d++) begin
                if (in_valid && in_ready_a[d]) begin
                    acc_cyc[d] = cyc + 1;
                    pend[d]    = 1'b1;
                end
                if (out_valid_a[d] && !prev_ov[d] && pend[d]) begin
                    chk("latency", d, 128'(cyc - acc_cyc[d]), 128'(4 / (1 << d) + 1));
                    pend[d] = 1'b0;
                end
                if (out_valid_a[d] && out_ready) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output dut%0d: got %h expected none", d, out_state_a[d]);
                    end else begin
                        chk("out_state", d, out_state_a[d], exp_q[d].pop_front());
                    end
                end
            end
        end
        prev_ov = out_valid_a;
    end

    task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] exp);
        int n;
        n = 0;
        while (!(&in_ready_a)) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready=%b expected all ones", in_ready_a);
                return;
            end
        end
        in_state   = s;
        in_inverse = inv;
        in_valid   = 1'b1;
        for (int d = 0; d < NDUT; d++) exp_q[d].push_back(exp);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        // Data and mode changes after accept must not matter
        in_state   = {$urandom, $urandom, $urandom, $urandom};
        in_inverse = ~inv;
    endtask

    task automatic wait_drain(input bit rnd);
        int n;
        n = 0;
        while (!((exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0) && (&in_ready_a))) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: pending=%0d/%0d/%0d expected 0", exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
                for (int d = 0; d < NDUT; d++) exp_q[d].delete();
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    localparam logic [127:0] V_A    = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] V_B    = 128'h4773b91ff72f354361cb018ea1e6cf2c;
    localparam logic [127:0] V_C_IN = 128'hdb135345f20a225cd4d4d4d52d26314c;
    localparam logic [127:0] V_C_FW = 128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8;
    localparam logic [127:0] V_D_IN = 128'h00000000000000000000000000000001;
    localparam logic [127:0] V_D_FW = 128'h00000000000000000000000001010302;
    localparam logic [127:0] V_D_IV = 128'h000000000000000000000000090d0b0e;
    localparam logic [127:0] V_E_IN = 128'hfde3bad205e5d0d73547964ef1fe37f1;
    localparam logic [127:0] V_E_IV = 128'h2d7e86a339d9393ee6570a1101904e16;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] held;
        logic [127:0] x;
        logic [127:0] y;
        int n;
        for (int d = 0; d < NDUT; d++) begin
            pend[d]    = 1'b0;
            acc_cyc[d] = 0;
        end
        prev_ov    = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_state   = V_A;
        in_inverse = 1'b1;
        out_ready  = 1'b0;

        // Reset with in_valid held high
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_in_ready", d, 128'(in_ready_a[d]), 128'd1);
            chk("rst_out_valid", d, 128'(out_valid_a[d]), 128'd0);
            chk("rst_out_state", d, out_state_a[d], 128'd0);
            chk("rst_busy", d, 128'(busy_a[d]), 128'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Directed vectors, both modes
        send(V_A, 1'b1, V_B);        wait_drain(1'b0);
        send(V_B, 1'b0, V_A);        wait_drain(1'b0);
        send(V_C_IN, 1'b0, V_C_FW);  wait_drain(1'b0);
        send(V_C_FW, 1'b1, V_C_IN);  wait_drain(1'b0);
        send(V_D_IN, 1'b0, V_D_FW);  wait_drain(1'b0);
        send(V_D_IN, 1'b1, V_D_IV);  wait_drain(1'b0);
        send('0, 1'b1, '0);          wait_drain(1'b0);

        // Backpressure in DONE for 10 cycles
        out_ready = 1'b0;
        send(V_B, 1'b0, V_A);
        n = 0;
        while (!(&out_valid_a) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                chk("bp_out_valid", d, 128'(out_valid_a[d]), 128'd1);
                chk("bp_out_state", d, out_state_a[d], V_A);
                chk("bp_in_ready", d, 128'(in_ready_a[d]), 128'd0);
            end
        end
        // Release with a new input offered in the same cycle: it must not be taken then
        @(posedge clk); #1;
        in_state   = V_A;
        in_inverse = 1'b1;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("rel_in_ready", d, 128'(in_ready_a[d]), 128'd1);
            chk("rel_out_valid", d, 128'(out_valid_a[d]), 128'd0);
            chk("rel_busy", d, 128'(busy_a[d]), 128'd0);
            chk("rel_out_hold", d, out_state_a[d], V_A);
            exp_q[d].push_back(V_B);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain(1'b0);

        // Reset after one RUN cycle discards the transfer
        send(V_E_IN, 1'b1, V_E_IV);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            exp_q[d].delete();
            pend[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("midrst_out_valid", d, 128'(out_valid_a[d]), 128'd0);
            chk("midrst_in_ready", d, 128'(in_ready_a[d]), 128'd1);
            chk("midrst_busy", d, 128'(busy_a[d]), 128'd0);
        end
        @(posedge clk); #1;
        send(V_E_IN, 1'b1, V_E_IV);  wait_drain(1'b0);

        // Random round trips with random output backpressure
        for (int i = 0; i < 150; i++) begin
            logic m;
            x = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            y = ref_mix(x, m);
            send(x, m, y);   wait_drain(1'b1);
            send(y, ~m, x);  wait_drain(1'b1);
        end

        held = '0;
        held = held;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
